// File: rtl/dataplane_pkg.sv
// Shared constants for the Zynq dataplane: register byte offsets, ID value,
// AXI response codes and CTRL bit positions.
package dataplane_pkg;

    localparam logic [5:0] OFF_CTRL     = 6'h00;
    localparam logic [5:0] OFF_STATUS   = 6'h04;
    localparam logic [5:0] OFF_PKT_CNT  = 6'h08;
    localparam logic [5:0] OFF_BYTE_CNT = 6'h0C;
    localparam logic [5:0] OFF_SCRATCH  = 6'h10;
    localparam logic [5:0] OFF_ID       = 6'h14;

    localparam logic [31:0] ID_VALUE = 32'hDA7A_0001;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int CTRL_RX_EN_BIT   = 0;
    localparam int CTRL_CNT_CLR_BIT = 1;

    // Only the six registers in the first 64-byte window are mapped; bits 1:0 are don't-care.
    function automatic logic addr_mapped(input logic [31:0] addr);
        return (addr[31:6] == '0) && ({addr[5:2], 2'b00} <= OFF_ID);
    endfunction

endpackage

// File: rtl/dataplane_if.sv
// AXI4-Lite slave port plus AXI-Stream RX sink of the dataplane, bundled as one interface.
interface dataplane_if #(
    parameter int DATA_WIDTH = 64
) ();

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // once valid is raised its payload stays stable until that edge.
    logic [31:0]             AWADDR;
    logic [2:0]              AWPROT;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [31:0]             WDATA;
    logic [3:0]              WSTRB;
    logic                    WVALID;
    logic                    WREADY;
    logic                    BVALID;
    logic [1:0]              BRESP;
    logic                    BREADY;
    logic [31:0]             ARADDR;
    logic [2:0]              ARPROT;
    logic                    ARVALID;
    logic                    ARREADY;
    logic                    RVALID;
    logic [31:0]             RDATA;
    logic [1:0]              RRESP;
    logic                    RREADY;
    logic                    tvalid;
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tlast;
    logic                    tready;

    modport master (
        output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
        output ARADDR, ARPROT, ARVALID, RREADY,
        output tvalid, tdata, tkeep, tlast,
        input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP, tready
    );

    modport slave (
        input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
        input  ARADDR, ARPROT, ARVALID, RREADY,
        input  tvalid, tdata, tkeep, tlast,
        output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP, tready
    );

endinterface

// File: rtl/axis_rx_stats.sv
// Packet/byte counters and in-frame tracking for the AXI-Stream RX sink.
// Byte counting is built only when DATAPLANE_BYTE_CNT_EN is defined.
module axis_rx_stats #(
    parameter int KEEP_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  beat,
    input  logic                  last,
    input  logic [KEEP_WIDTH-1:0] keep,
    input  logic                  clr,
    output logic [31:0]           pkt_cnt,
    output logic [31:0]           byte_cnt,
    output logic                  in_frame
);

    // A clear beats a beat accepted in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt  <= '0;
            in_frame <= 1'b0;
        end else if (clr) begin
            pkt_cnt  <= '0;
            in_frame <= 1'b0;
        end else if (beat) begin
            pkt_cnt  <= pkt_cnt + {31'b0, last};
            in_frame <= !last;
        end
    end

`ifdef DATAPLANE_BYTE_CNT_EN
    logic [31:0] keep_bytes;

    always_comb begin
        keep_bytes = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            keep_bytes = keep_bytes + {31'b0, keep[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= '0;
        end else if (clr) begin
            byte_cnt <= '0;
        end else if (beat) begin
            byte_cnt <= byte_cnt + keep_bytes;
        end
    end
`else
    logic unused_keep;
    assign unused_keep = ^keep;
    assign byte_cnt    = '0;
`endif

endmodule

// File: rtl/zynq_dataplane_top.sv
// AXI4-Lite register slave with an AXI-Stream RX statistics sink.
// Optional byte counter: define DATAPLANE_BYTE_CNT_EN.
module zynq_dataplane_top
    import dataplane_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input logic        clk,
    input logic        rst_n,
    dataplane_if.slave bus
);

    logic        ready_en;
    logic        aw_held;
    logic        w_held;
    logic [31:0] aw_addr_q;
    logic [31:0] w_data_q;
    logic [3:0]  w_strb_q;
    logic        bvalid_q;
    logic [1:0]  bresp_q;
    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;
    logic        rx_en;
    logic [31:0] scratch;
    logic [31:0] pkt_cnt;
    logic [31:0] byte_cnt;
    logic        in_frame;
    logic        do_write;
    logic        wr_mapped;
    logic [5:0]  wr_off;
    logic        cnt_clr;
    logic        rd_mapped;
    logic [5:0]  rd_off;
    logic [31:0] rd_data;
    logic [31:0] scratch_merged;
    logic        unused_ok;

    assign unused_ok = ^{bus.AWPROT, bus.ARPROT, bus.tdata};

    // ready_en keeps every ready low until the first edge after reset release.
    assign bus.AWREADY = ready_en && !aw_held && !bvalid_q;
    assign bus.WREADY  = ready_en && !w_held && !bvalid_q;
    assign bus.ARREADY = ready_en && !rvalid_q;
    assign bus.BVALID  = bvalid_q;
    assign bus.BRESP   = bresp_q;
    assign bus.RVALID  = rvalid_q;
    assign bus.RDATA   = rdata_q;
    assign bus.RRESP   = rresp_q;
    assign bus.tready  = rx_en;

    assign do_write  = aw_held && w_held;
    assign wr_mapped = addr_mapped(aw_addr_q);
    assign wr_off    = {aw_addr_q[5:2], 2'b00};
    assign cnt_clr   = do_write && wr_mapped && (wr_off == OFF_CTRL)
                       && w_strb_q[0] && w_data_q[CTRL_CNT_CLR_BIT];

    always_comb begin
        scratch_merged = scratch;
        for (int b = 0; b < 4; b++) begin
            if (w_strb_q[b]) scratch_merged[b*8 +: 8] = w_data_q[b*8 +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en  <= 1'b0;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rx_en     <= 1'b0;
            scratch   <= '0;
        end else begin
            ready_en <= 1'b1;
            if (bus.AWVALID && bus.AWREADY) begin
                aw_held   <= 1'b1;
                aw_addr_q <= bus.AWADDR;
            end
            if (bus.WVALID && bus.WREADY) begin
                w_held   <= 1'b1;
                w_data_q <= bus.WDATA;
                w_strb_q <= bus.WSTRB;
            end
            if (do_write) begin
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
                bvalid_q <= 1'b1;
                bresp_q  <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
                if (wr_mapped && wr_off == OFF_CTRL && w_strb_q[0]) begin
                    rx_en <= w_data_q[CTRL_RX_EN_BIT];
                end
                if (wr_mapped && wr_off == OFF_SCRATCH) begin
                    scratch <= scratch_merged;
                end
            end else if (bvalid_q && bus.BREADY) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    assign rd_mapped = addr_mapped(bus.ARADDR);
    assign rd_off    = {bus.ARADDR[5:2], 2'b00};

    always_comb begin
        rd_data = '0;
        if (rd_mapped) begin
            case (rd_off)
                OFF_CTRL:     rd_data[CTRL_RX_EN_BIT] = rx_en;
                OFF_STATUS:   rd_data[1:0] = {rx_en, in_frame};
                OFF_PKT_CNT:  rd_data = pkt_cnt;
                OFF_BYTE_CNT: rd_data = byte_cnt;
                OFF_SCRATCH:  rd_data = scratch;
                OFF_ID:       rd_data = ID_VALUE;
                default:      rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else if (bus.ARVALID && bus.ARREADY) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_data;
            rresp_q  <= rd_mapped ? RESP_OKAY : RESP_SLVERR;
        end else if (rvalid_q && bus.RREADY) begin
            rvalid_q <= 1'b0;
        end
    end

    axis_rx_stats #(
        .KEEP_WIDTH(DATA_WIDTH / 8)
    ) u_rx_stats (
        .clk      (clk),
        .rst_n    (rst_n),
        .beat     (bus.tvalid && rx_en),
        .last     (bus.tlast),
        .keep     (bus.tkeep),
        .clr      (cnt_clr),
        .pkt_cnt  (pkt_cnt),
        .byte_cnt (byte_cnt),
        .in_frame (in_frame)
    );

endmodule

// File: tb/tb_zynq_dataplane_top.sv
// Self-checking bench for zynq_dataplane_top: register table, hand-written
// handshake/clear corner cases and a randomized stream against a counting model.
module tb_zynq_dataplane_top;

    localparam int DW        = 64;
    localparam int CYC_LIMIT = 50;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] exp_q[$];

    dataplane_if #(.DATA_WIDTH(DW)) bus ();

    zynq_dataplane_top #(.DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        string       name;
    } vec_t;

    vec_t vecs[14];

    function automatic logic [31:0] exp_bytes(input logic [31:0] n);
`ifdef DATAPLANE_BYTE_CNT_EN
        return n;
`else
        return 32'(0) & n;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out after %0d cycles", name, CYC_LIMIT);
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        logic aw_hs;
        logic w_hs;
        int   n;
        bus.AWADDR  = addr;
        bus.AWVALID = 1'b1;
        bus.WDATA   = data;
        bus.WSTRB   = strb;
        bus.WVALID  = 1'b1;
        bus.BREADY  = 1'b0;
        n = 0;
        while ((bus.AWVALID || bus.WVALID) && n < CYC_LIMIT) begin
            aw_hs = bus.AWVALID && bus.AWREADY;
            w_hs  = bus.WVALID && bus.WREADY;
            step();
            n++;
            if (aw_hs) bus.AWVALID = 1'b0;
            if (w_hs)  bus.WVALID  = 1'b0;
        end
        n = 0;
        while (!bus.BVALID && n < CYC_LIMIT) begin
            step();
            n++;
        end
        if (!bus.BVALID) begin
            timeout("write_resp");
            bus.AWVALID = 1'b0;
            bus.WVALID  = 1'b0;
            resp = 2'b11;
            return;
        end
        resp = bus.BRESP;
        bus.BREADY = 1'b1;
        step();
        bus.BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        logic ar_hs;
        int   n;
        bus.ARADDR  = addr;
        bus.ARVALID = 1'b1;
        bus.RREADY  = 1'b0;
        n = 0;
        while (bus.ARVALID && n < CYC_LIMIT) begin
            ar_hs = bus.ARREADY;
            step();
            n++;
            if (ar_hs) bus.ARVALID = 1'b0;
        end
        n = 0;
        while (!bus.RVALID && n < CYC_LIMIT) begin
            step();
            n++;
        end
        if (!bus.RVALID) begin
            timeout("read_data");
            bus.ARVALID = 1'b0;
            data = '1;
            resp = 2'b11;
            return;
        end
        data = bus.RDATA;
        resp = bus.RRESP;
        bus.RREADY = 1'b1;
        step();
        bus.RREADY = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        logic [1:0]  r;
        axi_read(addr, d, r);
        check({name, "_data"}, d, exp);
        check({name, "_resp"}, {30'b0, r}, 32'(2'b00));
    endtask

    task automatic send_beat(input logic [7:0] keep, input logic last);
        int n = 0;
        bus.tvalid = 1'b1;
        bus.tkeep  = keep;
        bus.tlast  = last;
        bus.tdata  = {$urandom, $urandom};
        while (!bus.tready && n < CYC_LIMIT) begin
            step();
            n++;
        end
        if (!bus.tready) timeout("stream_beat");
        step();
        bus.tvalid = 1'b0;
        bus.tlast  = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        int          m_pkt;
        int          m_bytes;
        logic        m_in_frame;
        logic        acc;

        vecs[0]  = '{1'b0, 32'h14, 32'h0, 4'h0, 32'hDA7A_0001, 2'b00, "id_after_reset"};
        vecs[1]  = '{1'b0, 32'h08, 32'h0, 4'h0, 32'h0,         2'b00, "pkt_after_reset"};
        vecs[2]  = '{1'b1, 32'h10, 32'hA5A5_5A5A, 4'hF, 32'h0, 2'b00, "scratch_wr_full"};
        vecs[3]  = '{1'b1, 32'h10, 32'h0000_00FF, 4'h1, 32'h0, 2'b00, "scratch_wr_lane0"};
        vecs[4]  = '{1'b0, 32'h10, 32'h0, 4'h0, 32'hA5A5_5AFF, 2'b00, "scratch_rd"};
        vecs[5]  = '{1'b1, 32'h40, 32'hFFFF_FFFF, 4'hF, 32'h0, 2'b10, "unmapped_wr"};
        vecs[6]  = '{1'b0, 32'h40, 32'h0, 4'h0, 32'h0,         2'b10, "unmapped_rd"};
        vecs[7]  = '{1'b1, 32'h14, 32'h1234_5678, 4'hF, 32'h0, 2'b00, "ro_id_wr"};
        vecs[8]  = '{1'b0, 32'h14, 32'h0, 4'h0, 32'hDA7A_0001, 2'b00, "id_unchanged"};
        vecs[9]  = '{1'b0, 32'h00, 32'h0, 4'h0, 32'h0,         2'b00, "ctrl_reset"};
        vecs[10] = '{1'b0, 32'h0C, 32'h0, 4'h0, 32'h0,         2'b00, "bytes_reset"};
        vecs[11] = '{1'b0, 32'h18, 32'h0, 4'h0, 32'h0,         2'b10, "hole_rd"};
        vecs[12] = '{1'b1, 32'h13, 32'h1122_3344, 4'hC, 32'h0, 2'b00, "scratch_wr_hi_lowbits"};
        vecs[13] = '{1'b0, 32'h11, 32'h0, 4'h0, 32'h1122_5AFF, 2'b00, "scratch_rd_lowbits"};

        bus.AWADDR = '0; bus.AWPROT = '0; bus.AWVALID = 1'b0;
        bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 1'b0; bus.BREADY = 1'b0;
        bus.ARADDR = '0; bus.ARPROT = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;
        bus.tvalid = 1'b0; bus.tdata = '0; bus.tkeep = '0; bus.tlast = 1'b0;

        // Clock/reset
        rst_n = 1'b0;
        repeat (3) step();
        check("rst_awready", {31'b0, bus.AWREADY}, 32'h0);
        check("rst_wready",  {31'b0, bus.WREADY},  32'h0);
        check("rst_arready", {31'b0, bus.ARREADY}, 32'h0);
        check("rst_bvalid",  {31'b0, bus.BVALID},  32'h0);
        check("rst_rvalid",  {31'b0, bus.RVALID},  32'h0);
        check("rst_tready",  {31'b0, bus.tready},  32'h0);
        check("rst_rdata",   bus.RDATA, 32'h0);
        rst_n = 1'b1;
        check("awready_before_edge", {31'b0, bus.AWREADY}, 32'h0);
        step();
        check("awready_after_rst", {31'b0, bus.AWREADY}, 32'h1);
        check("wready_after_rst",  {31'b0, bus.WREADY},  32'h1);
        check("arready_after_rst", {31'b0, bus.ARREADY}, 32'h1);

        // Register table
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].is_write) begin
                axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, r);
                check({vecs[i].name, "_bresp"}, {30'b0, r}, {30'b0, vecs[i].exp_resp});
            end else begin
                axi_read(vecs[i].addr, d, r);
                check({vecs[i].name, "_data"}, d, vecs[i].exp_data);
                check({vecs[i].name, "_rresp"}, {30'b0, r}, {30'b0, vecs[i].exp_resp});
            end
        end

        // Three-beat frame
        axi_write(32'h00, 32'h1, 4'hF, r);
        check("ctrl_en_bresp", {30'b0, r}, 32'h0);
        check("tready_enabled", {31'b0, bus.tready}, 32'h1);
        send_beat(8'hFF, 1'b0);
        send_beat(8'hFF, 1'b0);
        send_beat(8'h0F, 1'b1);
        read_check("frame_pkt", 32'h08, 32'd1);
        read_check("frame_bytes", 32'h0C, exp_bytes(32'd20));
        read_check("frame_status", 32'h04, 32'h2);

        // AW three cycles ahead of W, BREADY held low
        bus.AWADDR = 32'h10; bus.AWVALID = 1'b1; bus.BREADY = 1'b0;
        step();
        bus.AWVALID = 1'b0;
        check("aw_latched_blocks", {31'b0, bus.AWREADY}, 32'h0);
        repeat (2) step();
        bus.WDATA = 32'hCAFE_F00D; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
        step();
        bus.WVALID = 1'b0;
        check("bvalid_not_yet", {31'b0, bus.BVALID}, 32'h0);
        step();
        check("bvalid_asserted", {31'b0, bus.BVALID}, 32'h1);
        repeat (5) step();
        check("bvalid_held", {31'b0, bus.BVALID}, 32'h1);
        check("bresp_held", {30'b0, bus.BRESP}, 32'h0);
        bus.BREADY = 1'b1;
        step();
        bus.BREADY = 1'b0;
        check("bvalid_cleared", {31'b0, bus.BVALID}, 32'h0);
        read_check("split_write_data", 32'h10, 32'hCAFE_F00D);

        // Counter clear colliding with a tlast beat
        send_beat(8'hFF, 1'b0);
        bus.AWADDR = 32'h00; bus.WDATA = 32'h3; bus.WSTRB = 4'hF;
        bus.AWVALID = 1'b1; bus.WVALID = 1'b1; bus.BREADY = 1'b1;
        step();
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
        bus.tvalid = 1'b1; bus.tlast = 1'b1; bus.tkeep = 8'hFF;
        step();
        bus.tvalid = 1'b0; bus.tlast = 1'b0;
        check("clr_bvalid", {31'b0, bus.BVALID}, 32'h1);
        step();
        bus.BREADY = 1'b0;
        read_check("clr_pkt", 32'h08, 32'h0);
        read_check("clr_bytes", 32'h0C, 32'h0);
        read_check("clr_status", 32'h04, 32'h2);
        read_check("clr_ctrl", 32'h00, 32'h1);

        // Disable mid-frame: stream stalls, in_frame kept
        send_beat(8'h03, 1'b0);
        axi_write(32'h00, 32'h0, 4'hF, r);
        check("stall_tready", {31'b0, bus.tready}, 32'h0);
        bus.tvalid = 1'b1; bus.tlast = 1'b1; bus.tkeep = 8'hFF;
        repeat (4) step();
        bus.tvalid = 1'b0; bus.tlast = 1'b0;
        read_check("stall_status", 32'h04, 32'h1);
        read_check("stall_pkt", 32'h08, 32'h0);
        read_check("stall_bytes", 32'h0C, exp_bytes(32'd2));

        // Randomized stream against a counting model
        axi_write(32'h00, 32'h3, 4'hF, r);
        m_pkt = 0;
        m_bytes = 0;
        m_in_frame = 1'b0;
        for (int c = 0; c < 400; c++) begin
            bus.tvalid = 1'($urandom_range(0, 1));
            bus.tkeep  = 8'($urandom);
            bus.tlast  = ($urandom_range(0, 3) == 0);
            bus.tdata  = {$urandom, $urandom};
            acc = bus.tvalid;
            if (acc) begin
                m_pkt      = m_pkt + (bus.tlast ? 1 : 0);
                m_bytes    = m_bytes + $countones(bus.tkeep);
                m_in_frame = !bus.tlast;
            end
            step();
        end
        bus.tvalid = 1'b0;
        bus.tlast  = 1'b0;
        exp_q.push_back(32'(m_pkt));
        exp_q.push_back(exp_bytes(32'(m_bytes)));
        exp_q.push_back({30'b0, 1'b1, m_in_frame});
        read_check("rand_pkt", 32'h08, exp_q.pop_front());
        read_check("rand_bytes", 32'h0C, exp_q.pop_front());
        read_check("rand_status", 32'h04, exp_q.pop_front());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/zynq_dataplane_top.md
ZYNQ_DATAPLANE_TOP -- requirements
Module: zynq_dataplane_top

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-002 Parameter: DATA_WIDTH, 64, AXI-Stream tdata width; legal values 8..512, multiple of 8.
REQ-003 Port: clk  input  1  sole clock; all logic on rising edge.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Ports: AWADDR input 32, AWPROT input 3 (ignored), AWVALID input 1, AWREADY output 1 -- AXI4-Lite write address.
REQ-006 Ports: WDATA input 32, WSTRB input 4, WVALID input 1, WREADY output 1 -- AXI4-Lite write data.
REQ-007 Ports: BVALID output 1, BRESP output 2, BREADY input 1 -- AXI4-Lite write response.
REQ-008 Ports: ARADDR input 32, ARPROT input 3 (ignored), ARVALID input 1, ARREADY output 1 -- AXI4-Lite read address.
REQ-009 Ports: RVALID output 1, RDATA output 32, RRESP output 2, RREADY input 1 -- AXI4-Lite read data.
REQ-010 Ports: tvalid input 1, tdata input DATA_WIDTH, tkeep input DATA_WIDTH/8, tlast input 1, tready output 1 -- AXI-Stream RX sink.

Function
REQ-011 Register map, decoded on ADDR[5:2], ADDR[1:0] ignored: 0x00 CTRL RW, 0x04 STATUS RO, 0x08 RX_PKT_CNT RO, 0x0C RX_BYTE_CNT RO, 0x10 SCRATCH RW, 0x14 ID RO = 0xDA7A_0001.
REQ-012 CTRL: bit0 rx_en (RW); bit1 cnt_clr (write-1 pulse, reads 0); bits 31:2 read 0.
REQ-013 STATUS: bit0 in_frame; bit1 mirrors rx_en; other bits 0.
REQ-014 AW and W accepted independently; AWREADY high while no address latched and BVALID low; WREADY high while no data latched and BVALID low.
REQ-015 Once both address and data are latched, write performed in that cycle with WSTRB byte-lane masking; BVALID asserts the next cycle.
REQ-016 BVALID held with BRESP stable until BREADY; cleared the cycle after the BVALID&BREADY handshake.
REQ-017 BRESP = 2'b00 for mapped addresses; writes to RO registers ignored with OKAY; unmapped address -> 2'b10 SLVERR, no state change.
REQ-018 ARREADY = !RVALID; on handshake RDATA/RRESP registered, RVALID asserts next cycle, held stable until RREADY.
REQ-019 Unmapped read -> RDATA 0, RRESP 2'b10; mapped read -> RRESP 2'b00.
REQ-020 tready = rx_en (combinational from register); beat accepted when tvalid&tready.
REQ-021 Accepted beat adds popcount(tkeep) to RX_BYTE_CNT; accepted beat with tlast increments RX_PKT_CNT.
REQ-022 in_frame set on accepted beat without tlast; cleared on accepted beat with tlast.
REQ-023 Counters 32-bit, wrap 0xFFFF_FFFF -> 0 silently.
REQ-024 cnt_clr zeroes both counters and in_frame; clr wins over a same-cycle accepted beat.
REQ-025 Clearing rx_en mid-frame stalls stream; in_frame retained.

Reset
REQ-026 On rst_n low: CTRL, SCRATCH, counters, in_frame = 0; AWREADY, WREADY, ARREADY, BVALID, RVALID, tready = 0; BRESP, RRESP, RDATA = 0.
REQ-027 AWREADY, WREADY, ARREADY rise the first cycle after rst_n deasserts; reset mid-transaction abandons it with no response.

Configuration
REQ-028 Macro DATAPLANE_BYTE_CNT_EN: defined -> RX_BYTE_CNT per REQ-021; undefined -> no byte-count logic, 0x0C reads 0 with OKAY.

Structure
REQ-029 Package dataplane_pkg SHALL hold register offsets, ID constant, RESP_OKAY/RESP_SLVERR, CTRL bit indices.
REQ-030 Stream counters/in_frame SHALL live in sub-module axis_rx_stats; AXI-Lite slave and register file in top.

Verification
REQ-031 Read 0x14 after reset -> RDATA 0xDA7A_0001, RRESP 0; read 0x08 -> 0; tready 0.
REQ-032 Write 0x10 = 0xA5A5_5A5A, WSTRB 0xF, then WSTRB 0x1 data 0x0000_00FF -> BRESP 0; readback 0xA5A5_5AFF.
REQ-033 Write 0x00 = 1; send 3-beat frame tkeep 0xFF,0xFF,0x0F, tlast on beat 3 -> RX_PKT_CNT 1, RX_BYTE_CNT 20 (0 without macro), STATUS 0x2.
REQ-034 AW presented 3 cycles before W, BREADY low 5 cycles -> one write, BVALID held until BREADY.
REQ-035 Write/read 0x40 -> BRESP 2'b10, RRESP 2'b10, RDATA 0.
REQ-036 Write CTRL = 0x3 during accepted tlast beat -> counters read 0, rx_en stays 1.
